// File: rtl/foc_pkg.sv
// Shared definitions for the FOC current path: Park FSM states, rounding and
// saturation constants, and the quarter-wave sine table generator.
package foc_pkg;

    // Park transform sequencing states; the single multiplier is time-shared over M0..M3.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LUT  = 3'd1,
        ST_M0   = 3'd2,
        ST_M1   = 3'd3,
        ST_M2   = 3'd4,
        ST_M3   = 3'd5,
        ST_OUT  = 3'd6
    } park_state_e;

    // pi in Q60, used only while building the sine table at elaboration.
    localparam logic signed [127:0] PI_Q60 = 128'sh3243F6A8885A308D;

    // Half an LSB of the result, added before the arithmetic shift (round half up).
    function automatic int round_const(input int q_bits);
        return 1 << (q_bits - 1);
    endfunction

    // Largest representable result value for a D_WIDTH signed output.
    function automatic int sat_max(input int d_width);
        return (1 << (d_width - 1)) - 1;
    endfunction

    // Smallest representable result value for a D_WIDTH signed output.
    function automatic int sat_min(input int d_width);
        return -(1 << (d_width - 1));
    endfunction

    // T[k] = round(2**q_bits * sin(pi/2 * k/N)), N = 2**(ang_bits-2).
    // Integer Taylor series in Q60 keeps the table exact without real math,
    // and T[N] lands on exactly 2**q_bits.
    function automatic int quarter_sine(input int k, input int ang_bits, input int q_bits);
        logic signed [127:0] x;
        logic signed [127:0] term;
        logic signed [127:0] acc;
        logic signed [127:0] r;
        x    = (PI_Q60 * 128'(k)) / (128'sd1 <<< (ang_bits - 1));
        term = x;
        acc  = x;
        for (int n = 1; n <= 15; n++) begin
            term = (term * x) >>> 60;
            term = (term * x) >>> 60;
            term = -term / 128'(2 * n * (2 * n + 1));
            acc  = acc + term;
        end
        r = ((acc <<< q_bits) + (128'sd1 <<< 59)) >>> 60;
        return int'(r);
    endfunction

endpackage

// File: rtl/sincos_lut.sv
// Registered angle -> sin/cos lookup from a quarter-wave table with quadrant
// folding. One cycle of latency; shared with the inverse Park stage.
module sincos_lut
    import foc_pkg::*;
#(
    parameter int ANG_BITS = 10,
    parameter int Q_BITS   = 15
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       en_i,
    input  logic [ANG_BITS-1:0]        theta_i,
    output logic signed [Q_BITS+1:0]   sin_o,
    output logic signed [Q_BITS+1:0]   cos_o
);

    localparam int N = 1 << (ANG_BITS - 2);

    logic [Q_BITS+1:0]        rom [0:N];
    logic [1:0]               qd;
    logic [ANG_BITS-2:0]      idx;
    logic [ANG_BITS-2:0]      cidx;
    logic signed [Q_BITS+1:0] t_i;
    logic signed [Q_BITS+1:0] t_c;
    logic signed [Q_BITS+1:0] sin_d;
    logic signed [Q_BITS+1:0] cos_d;
    logic signed [Q_BITS+1:0] sin_q;
    logic signed [Q_BITS+1:0] cos_q;

    // Table entries are elaboration-time constants.
    for (genvar k = 0; k <= N; k++) begin : g_rom
        localparam int TV = quarter_sine(k, ANG_BITS, Q_BITS);
        assign rom[k] = (Q_BITS + 2)'(TV);
    end

    assign qd   = theta_i[ANG_BITS-1 -: 2];
    assign idx  = {1'b0, theta_i[ANG_BITS-3:0]};
    assign cidx = (ANG_BITS - 1)'(N) - idx;
    assign t_i  = $signed(rom[idx]);
    assign t_c  = $signed(rom[cidx]);

    // Fold the quarter-wave entries into full-circle sin and cos by quadrant.
    always_comb begin
        sin_d = '0;
        cos_d = '0;
        case (qd)
            2'd0: begin sin_d =  t_i; cos_d =  t_c; end
            2'd1: begin sin_d =  t_c; cos_d = -t_i; end
            2'd2: begin sin_d = -t_i; cos_d = -t_c; end
            default: begin sin_d = -t_c; cos_d = t_i; end
        endcase
    end

    // Output registers: the 1-cycle read latency of the lookup.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sin_q <= '0;
            cos_q <= '0;
        end else if (en_i) begin
            sin_q <= sin_d;
            cos_q <= cos_d;
        end
    end

    assign sin_o = sin_q;
    assign cos_o = cos_q;

endmodule

// File: rtl/park.sv
// Park transform: alpha/beta -> d/q with one shared multiplier, sequenced as
// IDLE -> LUT -> M0 -> M1 -> M2 -> M3 -> OUT. Handshake: start is sampled only
// in IDLE; done is a one-cycle pulse with d/q valid, and d/q hold until the
// next done. busy is high whenever the FSM is not IDLE.
module park
    import foc_pkg::*;
#(
    parameter int D_WIDTH  = 18,
    parameter int Q_BITS   = 15,
    parameter int ANG_BITS = 10
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic signed [D_WIDTH-1:0] alpha,
    input  logic signed [D_WIDTH-1:0] beta,
    input  logic [ANG_BITS-1:0]       theta,
    input  logic                      start,
    output logic signed [D_WIDTH-1:0] d,
    output logic signed [D_WIDTH-1:0] q,
    output logic                      done,
    output logic                      busy
);

    localparam int P_W   = 2 * D_WIDTH;
    localparam int ACC_W = 2 * D_WIDTH + 1;
    localparam int S_W   = Q_BITS + 2;

    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(round_const(Q_BITS));
    localparam logic signed [ACC_W-1:0] SAT_HI  = ACC_W'(sat_max(D_WIDTH));
    localparam logic signed [ACC_W-1:0] SAT_LO  = ACC_W'(sat_min(D_WIDTH));

    park_state_e               state_q;
    logic signed [D_WIDTH-1:0] alpha_q;
    logic signed [D_WIDTH-1:0] beta_q;
    logic [ANG_BITS-1:0]       theta_q;
    logic signed [ACC_W-1:0]   accd_q;
    logic signed [ACC_W-1:0]   accq_q;
    logic signed [D_WIDTH-1:0] d_q;
    logic signed [D_WIDTH-1:0] q_q;
    logic                      done_q;

    logic signed [S_W-1:0]     sin_v;
    logic signed [S_W-1:0]     cos_v;
    logic signed [D_WIDTH-1:0] mul_a;
    logic signed [S_W-1:0]     mul_b;
    logic signed [P_W-1:0]     prod;
    logic signed [ACC_W-1:0]   prod_ext;

    sincos_lut #(
        .ANG_BITS (ANG_BITS),
        .Q_BITS   (Q_BITS)
    ) u_lut (
        .clk     (clk),
        .rstb    (rstb),
        .en_i    (state_q == ST_LUT),
        .theta_i (theta_q),
        .sin_o   (sin_v),
        .cos_o   (cos_v)
    );

    // Operand select for the single shared multiplier.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            ST_M0:   begin mul_a = alpha_q; mul_b = cos_v; end
            ST_M1:   begin mul_a = beta_q;  mul_b = sin_v; end
            ST_M2:   begin mul_a = beta_q;  mul_b = cos_v; end
            ST_M3:   begin mul_a = alpha_q; mul_b = sin_v; end
            default: begin mul_a = '0;      mul_b = '0;    end
        endcase
    end

    assign prod     = P_W'(mul_a) * P_W'(mul_b);
    assign prod_ext = ACC_W'(prod);

    // Round half up, then clamp into the D_WIDTH signed range.
    function automatic logic signed [D_WIDTH-1:0] rnd_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
        r = (acc + RND) >>> Q_BITS;
        if (r > SAT_HI) r = SAT_HI;
        else if (r < SAT_LO) r = SAT_LO;
        return r[D_WIDTH-1:0];
    endfunction

    // Sequencer: latch inputs, walk the four MAC steps, register the result.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            alpha_q <= '0;
            beta_q  <= '0;
            theta_q <= '0;
            accd_q  <= '0;
            accq_q  <= '0;
            d_q     <= '0;
            q_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        alpha_q <= alpha;
                        beta_q  <= beta;
                        theta_q <= theta;
                        state_q <= ST_LUT;
                    end
                end
                ST_LUT: state_q <= ST_M0;
                ST_M0: begin
                    accd_q  <= prod_ext;
                    state_q <= ST_M1;
                end
                ST_M1: begin
                    accd_q  <= accd_q + prod_ext;
                    state_q <= ST_M2;
                end
                ST_M2: begin
                    accq_q  <= prod_ext;
                    state_q <= ST_M3;
                end
                ST_M3: begin
                    accq_q  <= accq_q - prod_ext;
                    state_q <= ST_OUT;
                end
                ST_OUT: begin
                    d_q     <= rnd_sat(accd_q);
                    q_q     <= rnd_sat(accq_q);
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign d    = d_q;
    assign q    = q_q;
    assign done = done_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_park.sv
// Directed bench for the Park transform with hand-computed expected d/q.
module tb_park;

    localparam int D_WIDTH  = 18;
    localparam int Q_BITS   = 15;
    localparam int ANG_BITS = 10;

    logic                      clk = 1'b0;
    logic                      rstb;
    logic signed [D_WIDTH-1:0] alpha;
    logic signed [D_WIDTH-1:0] beta;
    logic [ANG_BITS-1:0]       theta;
    logic                      start;
    logic signed [D_WIDTH-1:0] d;
    logic signed [D_WIDTH-1:0] q;
    logic                      done;
    logic                      busy;

    int     n_checks = 0;
    int     n_pass   = 0;
    longint exp_q[$];

    park #(
        .D_WIDTH  (D_WIDTH),
        .Q_BITS   (Q_BITS),
        .ANG_BITS (ANG_BITS)
    ) dut (
        .clk   (clk),
        .rstb  (rstb),
        .alpha (alpha),
        .beta  (beta),
        .theta (theta),
        .start (start),
        .d     (d),
        .q     (q),
        .done  (done),
        .busy  (busy)
    );

    // Clock and reset block
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    // Drive a start request; returns at E0 + 1.
    task automatic drive_start(input longint a, input longint b, input int t);
        @(negedge clk);
        alpha = D_WIDTH'(a);
        beta  = D_WIDTH'(b);
        theta = ANG_BITS'(t);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // From E0 + 1, wait for done; lat counts edges after E0.
    task automatic wait_done(input string tag, output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cnt++;
        end
        if (!done) check({tag, "_timeout"}, 0, 1);
    endtask

    // Compare d/q against the next two scoreboard entries.
    task automatic score(input string tag);
        longint ed;
        longint eq;
        ed = exp_q.pop_front();
        eq = exp_q.pop_front();
        check({tag, "_d"}, d, ed);
        check({tag, "_q"}, q, eq);
    endtask

    task automatic xform(input string tag, input longint a, input longint b, input int t,
                         input longint ed, input longint eq);
        int lat;
        int bc;
        exp_q.push_back(ed);
        exp_q.push_back(eq);
        drive_start(a, b, t);
        wait_done(tag, lat, bc);
        check({tag, "_lat"}, lat, 6);
        score(tag);
    endtask

    initial begin
        int lat;
        int bc;
        int ndone;
        rstb  = 1'b0;
        start = 1'b0;
        alpha = '0;
        beta  = '0;
        theta = '0;
        #22;
        check("rst_d", d, 0);
        check("rst_q", q, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rstb = 1'b1;

        // theta=0: latency, busy window and single-cycle done
        exp_q.push_back(16384);
        exp_q.push_back(-8192);
        drive_start(16384, -8192, 0);
        wait_done("t0", lat, bc);
        check("t0_lat", lat, 6);
        check("t0_busy_cycles", bc, 6);
        score("t0");
        @(posedge clk);
        #1;
        check("t0_done_pulse", done, 0);

        xform("t90", 16384, 8192, 256, 8192, -16384);
        xform("t45", 32767, 32767, 128, 46339, 0);
        xform("t45_sat", 131071, 131071, 128, 131071, 0);
        xform("t45_rnd", 1, 0, 128, 1, -1);
        xform("t270", 3000, -4000, 768, 4000, 3000);

        // start re-asserted in M1 is ignored
        exp_q.push_back(2000);
        exp_q.push_back(0);
        drive_start(2000, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        alpha = 18'sd5;
        beta  = 18'sd7;
        theta = 10'd100;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 3;
        ndone = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) ndone++;
        end
        check("m1_lat", lat, 6);
        check("m1_ndone", ndone, 1);
        score("m1");

        // start held in the done cycle is accepted
        exp_q.push_back(-1000);
        exp_q.push_back(0);
        alpha = 18'sd1000;
        beta  = 18'sd0;
        theta = 10'd512;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", busy, 1);
        wait_done("b2b", lat, bc);
        check("b2b_lat", lat, 6);
        score("b2b");
        @(posedge clk); #1;
        check("b2b_single", done, 0);

        // reset during M2 aborts with no done
        drive_start(4000, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rstb = 1'b0;
        #1;
        check("arst_d", d, 0);
        check("arst_q", q, 0);
        check("arst_done", done, 0);
        check("arst_busy", busy, 0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("arst_nodone", ndone, 0);
        @(negedge clk);
        rstb = 1'b1;
        xform("post_rst", 3000, -4000, 0, 3000, -4000);

        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/park.md
Name: park

Overview:
- Park transform stage, directly downstream of the Clarke block in the FOC current path.
- Rotates stationary-frame alpha/beta into rotor-frame d/q using electrical angle theta:
  - d = alpha*cos(theta) + beta*sin(theta)
  - q = -alpha*sin(theta) + beta*cos(theta)
- Uses one shared multiplier, sequenced by an FSM, and a quarter-wave sin/cos ROM. Result is a start/done transaction.

Parameters:
- D_WIDTH, 18: signed data width of alpha/beta/d/q (Q3.15; must equal Clarke D_WIDTH).
- Q_BITS, 15: fractional bits of data and of the sin/cos table.
- ANG_BITS, 10: unsigned angle width; full circle = 2**ANG_BITS codes.

Ports:
- clk  in  1  clock
- rstb  in  1  asynchronous active-low reset
- alpha  in  D_WIDTH signed  stationary-frame alpha (Clarke alpha)
- beta  in  D_WIDTH signed  stationary-frame beta (Clarke beta)
- theta  in  ANG_BITS unsigned  electrical angle
- start  in  1  request; sampled only in IDLE
- d  out  D_WIDTH signed  direct-axis result
- q  out  D_WIDTH signed  quadrature-axis result
- done  out  1  one-cycle pulse, d/q valid
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: rstb is asynchronous, active-low; clock is clk. On reset, d=0, q=0, done=0, busy=0, accumulators=0, state=IDLE.
- Reset mid-transaction: abort immediately, no done pulse.
- States: IDLE -> LUT -> M0 -> M1 -> M2 -> M3 -> OUT -> IDLE.
- IDLE:
  - start=1 latches alpha, beta and theta, then goes to LUT.
  - start=0 stays in IDLE.
  - Later changes on the inputs are ignored.
- LUT: ROM output registers load sin/cos (1-cycle registered read).
- M0: acc_d = alpha*cos.
- M1: acc_d += beta*sin.
- M2: acc_q = beta*cos.
- M3: acc_q -= alpha*sin.
- OUT: round, saturate, register d/q, pulse done, return to IDLE.
- Latency: start is sampled at edge E0; d/q/done are registered at E6. done is high exactly for the cycle after E6.
- Throughput: one transform per 6 cycles.
- start is ignored while busy. start in the cycle where done=1 is accepted, because the state is already IDLE.
- d/q hold their last value between transactions.
- Arithmetic:
  - Products are 2*D_WIDTH signed.
  - Accumulators are 2*D_WIDTH+1 signed.
  - Result = (acc + 2**(Q_BITS-1)) >>> Q_BITS (round half up).
  - Saturate to [-(2**(D_WIDTH-1)), 2**(D_WIDTH-1)-1].
- Table:
  - N = 2**(ANG_BITS-2); T has N+1 entries.
  - T[k] = round(2**Q_BITS * sin(pi/2*k/N)), so T[N] = 2**Q_BITS exactly (1.0).
  - Quadrant is qd = theta[MSB:MSB-1]; index is i = theta low bits.
  - sin: qd0 = T[i], qd1 = T[N-i], qd2 = -T[i], qd3 = -T[N-i].
  - cos: qd0 = T[N-i], qd1 = -T[i], qd2 = -T[N-i], qd3 = T[i].
  - Sin/cos width is Q_BITS+2 signed.
- Angle wrap: theta = 2**ANG_BITS-1 followed by 0 is continuous; there is no special case.

Decomposition:
- Shared package foc_pkg holds:
  - the state enum;
  - the ROUND_CONST and saturation-limit constants as functions of D_WIDTH/Q_BITS;
  - the quarter-wave table generation function, computed at elaboration.
- Sub-module sincos_lut (ANG_BITS, Q_BITS): registered theta -> sin/cos with quadrant folding, 1-cycle latency. It will be reused by the inverse Park stage.

Test Plan:
- theta=0, alpha=16384, beta=-8192, start pulse -> done exactly 6 cycles after the start edge; d=16384, q=-8192; busy high for 6 cycles.
- theta=256 (90 deg), alpha=16384, beta=8192 -> d=8192, q=-16384.
- theta=128 (45 deg, T=23170), alpha=beta=32767 -> d=46339, q=0.
- theta=128, alpha=beta=131071 -> d saturates to 131071, q=0; no wrap.
- start re-asserted in M1 -> ignored, single done. Then start held high in the done cycle with theta=512 and alpha=1000, beta=0 -> second transaction gives d=-1000, q=0 (rounding is exact because T[N] = 2**Q_BITS exactly).
- rstb low during M2 -> d=q=0, done=0, busy=0 immediately. After release, a new start completes normally with correct values.
